// File: rtl/mux_4x1.sv
// mux_4x1: 4-to-1 data selector with a combinational result and a registered copy
module mux_4x1 #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             en,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] F_q,
  output logic             q_valid
);
  logic [WIDTH-1:0] data [4];
  always_comb begin
    data[0] = A;
    data[1] = B;
    data[2] = C;
    data[3] = D;
    F = data[{sel1, sel2}];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      F_q     <= RST_VAL;
      q_valid <= 1'b0;
    end else if (en) begin
      F_q     <= F;
      q_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_4x1.sv
// tb_mux_4x1: directed self-checking bench for mux_4x1 at WIDTH=1 and WIDTH=8
module tb_mux_4x1;
  logic clk = 1'b0;
  logic rst, sel1, sel2, en;
  logic a, b, c, d, f, f_q, q_valid;
  logic [7:0] a8, b8, c8, d8, f8, f8_q;
  logic q8_valid;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mux_4x1 #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d),
    .sel1(sel1), .sel2(sel2), .en(en), .F(f), .F_q(f_q), .q_valid(q_valid)
  );
  mux_4x1 #(.WIDTH(8), .RST_VAL(8'h3C)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .C(c8), .D(d8),
    .sel1(sel1), .sel2(sel2), .en(en), .F(f8), .F_q(f8_q), .q_valid(q8_valid)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [5:0] v;
    rst = 1'b1; en = 1'b1; sel1 = 1'b0; sel2 = 1'b0;
    {a, b, c, d} = 4'b1111;
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h5A; d8 = 8'h44;
    tick();
    check("rst_fq", {7'd0, f_q}, 8'h00);
    check("rst_qv", {7'd0, q_valid}, 8'h00);
    check("rst_fq8", f8_q, 8'h3C);
    check("rst_qv8", {7'd0, q8_valid}, 8'h00);
    rst = 1'b0; en = 1'b0;
    {a, b, c, d} = 4'b1000;
    #1;
    check("t1_f", {7'd0, f}, 8'h01);
    tick();
    check("en0_hold_fq", {7'd0, f_q}, 8'h00);
    check("en0_hold_qv", {7'd0, q_valid}, 8'h00);
    en = 1'b1;
    tick();
    check("t1_fq", {7'd0, f_q}, 8'h01);
    check("t1_qv", {7'd0, q_valid}, 8'h01);
    check("t1_fq8", f8_q, 8'h11);
    en = 1'b0;
    {a, b, c, d} = 4'b0100; sel1 = 1'b0; sel2 = 1'b1; #1;
    check("t2_f", {7'd0, f}, 8'h01);
    {a, b, c, d} = 4'b1011; #1;
    check("t2_f_other", {7'd0, f}, 8'h00);
    {a, b, c, d} = 4'b0010; sel1 = 1'b1; sel2 = 1'b0; #1;
    check("t3_f", {7'd0, f}, 8'h01);
    check("t3_f8", f8, 8'h5A);
    sel2 = 1'b1; #1;
    check("t3_f_d", {7'd0, f}, 8'h00);
    check("t3_f8_d", f8, 8'h44);
    {a, b, c, d} = 4'b0001; #1;
    check("t4_f", {7'd0, f}, 8'h01);
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      {a, b, c, d, sel1, sel2} = v;
      #1;
      check($sformatf("sweep_%0d", i), {7'd0, f}, {7'd0, v[5 - int'(v[1:0])]});
    end
    tick();
    check("t6_hold_fq", {7'd0, f_q}, 8'h01);
    check("t6_hold_qv", {7'd0, q_valid}, 8'h01);
    {a, b, c, d} = 4'b0000; sel1 = 1'b0; sel2 = 1'b0;
    tick();
    check("t6_hold2_fq", {7'd0, f_q}, 8'h01);
    rst = 1'b1; en = 1'b1; a = 1'b1;
    tick();
    check("t5_rst_fq", {7'd0, f_q}, 8'h00);
    check("t5_rst_qv", {7'd0, q_valid}, 8'h00);
    check("t5_rst_fq8", f8_q, 8'h3C);
    check("t5_f_tracks", {7'd0, f}, 8'h01);
    rst = 1'b0;
    tick();
    check("t5_rel_fq", {7'd0, f_q}, 8'h01);
    check("t5_rel_qv", {7'd0, q_valid}, 8'h01);
    a8 = 8'hA5; sel1 = 1'b0; sel2 = 1'b0;
    tick();
    check("t6_w8_fq", f8_q, 8'hA5);
    check("t6_w8_qv", {7'd0, q8_valid}, 8'h01);
    en = 1'b0; a8 = 8'h00; a = 1'b0;
    tick();
    check("t6_w8_hold", f8_q, 8'hA5);
    check("t6_w1_hold", {7'd0, f_q}, 8'h01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
